// File: rtl/pim_pkg.sv
// Shared definitions for the PIM array: request codes and the PE ALU state
// encoding, also used by the controller's operation decode.
package pim_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

  // True when the controller is presenting any request (including reserved).
  function automatic logic op_is_req(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/pim_seq_mult.sv
// Iterative shift-add multiplier. i_start loads the operands and clears the
// accumulator; one multiplier bit (LSB first) is consumed per clock after
// that. o_done is high combinationally during the final step, with o_product
// carrying the completed product, so the caller can register it on the same
// edge. i_abort stops a running multiplication without completing it.
module pim_seq_mult
  import pim_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;

  logic [2*DATA_W-1:0] w_acc_next;
  logic                w_last;

  // Partial-product add: multiplicand is kept pre-shifted by the step count.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_last     = r_run && (r_cnt == LAST_CNT);
  end

  assign o_done    = w_last && !i_abort;
  assign o_product = w_acc_next;

  // Operand load, per-bit iteration, and stop on completion or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (i_abort) begin
        r_run <= 1'b0;
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pim_pe_alu.sv
// Per-PE arithmetic responder on the controller's operation/op_done
// handshake. ADD completes one edge after acceptance, MUL after DATA_W
// iteration edges; the result is held until the next accepted request.
module pim_pe_alu
  import pim_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        operation,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              op_done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              busy,
  output logic              err
);

  alu_state_t r_state;
  alu_state_t w_state_next;

  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic              r_done;
  logic              r_err;

  logic                w_req;
  logic                w_start_mul;
  logic                w_abort;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_sum;

  assign w_req       = op_is_req(operation);
  assign w_start_mul = (r_state == ST_IDLE) && (operation == OP_MUL);
  assign w_abort     = (r_state == ST_BUSY) && !w_req;
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};

  pim_seq_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start_mul),
    .i_abort   (w_abort),
    .i_a       (opa),
    .i_b       (opb),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode: requests accepted only from IDLE, withdrawal aborts
  // BUSY and releases DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_state_next = (operation == OP_RSV) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (!w_req)                w_state_next = ST_IDLE;
        else if (r_op == OP_ADD)   w_state_next = ST_DONE;
        else if (w_mul_done)       w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!w_req) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture and output registers. Carry is left alone on acceptance:
  // a completing op always overwrites it, while aborted and reserved
  // requests must leave the previous result/carry pair intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_NOP;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_op   <= operation;
            r_a    <= opa;
            r_b    <= opb;
            r_err  <= (operation == OP_RSV);
            r_done <= (operation == OP_RSV);
          end
        end
        ST_BUSY: begin
          if (w_req) begin
            if (r_op == OP_ADD) begin
              r_result <= w_sum[DATA_W-1:0];
              r_carry  <= w_sum[DATA_W];
              r_done   <= 1'b1;
            end else if (w_mul_done) begin
              r_result <= w_prod[DATA_W-1:0];
              r_carry  <= |w_prod[2*DATA_W-1:DATA_W];
              r_done   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!w_req) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        default: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
      endcase
    end
  end

  assign op_done = r_done;
  assign result  = r_result;
  assign carry   = r_carry;
  assign err     = r_err;
  assign busy    = (r_state == ST_BUSY);

endmodule

// File: tb/tb_pim_pe_alu.sv
module tb_pim_pe_alu;

  localparam int DW = 8;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  logic          clk;
  logic          reset;
  logic [1:0]    operation;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          op_done;
  logic [DW-1:0] result;
  logic          carry;
  logic          busy;
  logic          err;

  int n_chk;
  int n_err;

  // Reference state: what result/carry should currently be held.
  logic [DW-1:0] m_res;
  logic          m_carry;

  pim_pe_alu #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .op_done   (op_done),
    .result    (result),
    .carry     (carry),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          cy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op);
    if (op == ADD) return 2;
    if (op == MUL) return DW + 1;
    return 1;
  endfunction

  // Behavioural model computed directly from unsigned arithmetic.
  task automatic model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [DW-1:0] r, output logic c, output logic e);
    int unsigned s;
    s = 0;
    e = 1'b0;
    if (op == ADD) begin
      s = int'(a) + int'(b);
      r = DW'(s % (1 << DW));
      c = (s >= (1 << DW));
    end else if (op == MUL) begin
      s = int'(a) * int'(b);
      r = DW'(s % (1 << DW));
      c = (s >= (1 << DW));
    end else begin
      r = m_res;
      c = m_carry;
      e = 1'b1;
    end
  endtask

  // Issue one request, wait (bounded) for op_done, check latency/outputs,
  // optionally scramble operands while waiting, optionally withdraw.
  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] er, input logic ec, input logic ee,
                       input bit scramble, input bit drop, input string nm);
    int lat;
    int bcnt;
    bit got;
    @(negedge clk);
    operation = op;
    opa = a;
    opb = b;
    lat = 0;
    bcnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (op_done === 1'b1) got = 1;
      else begin
        if (busy === 1'b1) bcnt++;
        if (scramble) begin
          opa = DW'($urandom);
          opb = DW'($urandom);
        end
      end
    end
    chk({nm, ".done_seen"}, 32'(got), 32'd1);
    chk({nm, ".latency"}, lat, lat_of(op));
    chk({nm, ".busy_edges"}, bcnt, lat_of(op) - 1);
    chk({nm, ".result"}, 32'(result), 32'(er));
    chk({nm, ".carry"}, 32'(carry), 32'(ec));
    chk({nm, ".err"}, 32'(err), 32'(ee));
    m_res = er;
    m_carry = ec;
    if (drop) begin
      @(negedge clk);
      operation = NOP;
      opa = DW'($urandom);
      opb = DW'($urandom);
      @(posedge clk);
      #1;
      chk({nm, ".drop_done"}, 32'(op_done), 32'd0);
      chk({nm, ".drop_err"}, 32'(err), 32'd0);
      chk({nm, ".drop_result"}, 32'(result), 32'(er));
      chk({nm, ".drop_carry"}, 32'(carry), 32'(ec));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [DW-1:0] r;
    logic c;
    logic e;
    logic [1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    n_chk = 0;
    n_err = 0;
    m_res = '0;
    m_carry = 1'b0;
    reset = 1'b1;
    operation = NOP;
    opa = '0;
    opb = '0;

    vecs.push_back('{ADD, 8'd100, 8'd27,  8'd127, 1'b0});
    vecs.push_back('{ADD, 8'd200, 8'd100, 8'd44,  1'b1});
    vecs.push_back('{MUL, 8'd13,  8'd11,  8'd143, 1'b0});
    vecs.push_back('{MUL, 8'd20,  8'd20,  8'd144, 1'b1});
    vecs.push_back('{ADD, 8'd255, 8'd1,   8'd0,   1'b1});
    vecs.push_back('{ADD, 8'd0,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{MUL, 8'd255, 8'd255, 8'd1,   1'b1});
    vecs.push_back('{MUL, 8'd0,   8'd255, 8'd0,   1'b0});
    vecs.push_back('{MUL, 8'd16,  8'd16,  8'd0,   1'b1});
    vecs.push_back('{MUL, 8'd15,  8'd17,  8'd255, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset.op_done", 32'(op_done), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.carry", 32'(carry), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cy, 1'b0, 1'b0, 1'b1,
            $sformatf("vec%0d", i));
    end

    // Operand changes during BUSY must not alter the product.
    do_op(MUL, 8'd13, 8'd11, 8'd143, 1'b0, 1'b0, 1'b1, 1'b1, "mul_scramble");
    do_op(ADD, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b1, 1'b1, "add_scramble");

    // Hold the request past op_done with changing operands: no restart.
    do_op(MUL, 8'd13, 8'd11, 8'd143, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      opa = DW'($urandom);
      opb = DW'($urandom);
      @(posedge clk);
      #1;
      chk("hold.op_done", 32'(op_done), 32'd1);
      chk("hold.busy", 32'(busy), 32'd0);
      chk("hold.result", 32'(result), 32'd143);
    end
    @(negedge clk);
    operation = NOP;
    @(posedge clk);
    #1;
    chk("hold.release", 32'(op_done), 32'd0);
    chk("hold.kept", 32'(result), 32'd143);

    // Abort a MUL: request withdrawn at the third BUSY edge.
    do_op(ADD, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b0, 1'b1, "pre_abort");
    @(negedge clk);
    operation = MUL;
    opa = 8'd13;
    opb = 8'd11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    operation = NOP;
    @(posedge clk);
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("abort.op_done", 32'(op_done), 32'd0);
    end
    chk("abort.result", 32'(result), 32'd44);
    chk("abort.carry", 32'(carry), 32'd1);
    do_op(MUL, 8'd3, 8'd5, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1, "after_abort");

    // Reset in the middle of a MUL.
    do_op(ADD, 8'd250, 8'd10, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    operation = MUL;
    opa = 8'd99;
    opb = 8'd77;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset.op_done", 32'(op_done), 32'd0);
    chk("midreset.result", 32'(result), 32'd0);
    chk("midreset.carry", 32'(carry), 32'd0);
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    operation = NOP;
    m_res = '0;
    m_carry = 1'b0;
    do_op(MUL, 8'd7, 8'd9, 8'd63, 1'b0, 1'b0, 1'b0, 1'b1, "after_reset");

    // Reserved request, then ADD 1+1 after a single NOP cycle.
    do_op(ADD, 8'd128, 8'd129, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, "pre_rsv");
    do_op(RSV, 8'd5, 8'd6, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1, "rsv");
    do_op(ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, "add_after_rsv");

    // Randomized requests against the reference model.
    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(1, 3));
      a = DW'($urandom);
      b = DW'($urandom);
      model(op, a, b, r, c, e);
      do_op(op, a, b, r, c, e, bit'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
